// File: rtl/hyperbus_delay_cal_pkg.sv
// Shared types and helpers for the hyperbus receive-path delay calibration.
package hyperbus_delay_cal_pkg;

  typedef enum logic [2:0] {
    CAL_IDLE   = 3'd0,
    CAL_SET    = 3'd1,
    CAL_SETTLE = 3'd2,
    CAL_TEST   = 3'd3,
    CAL_EVAL   = 3'd4,
    CAL_FINISH = 3'd5
  } cal_state_e;

  localparam int CAL_BIT_WIDTH = 3;
  localparam int N_TAPS        = 1 << CAL_BIT_WIDTH;

  // Widest delay code the centre helper accepts; callers zero-extend into it.
  localparam int CODE_W_MAX = 16;

  // Floor of the midpoint, summed one bit wider so the carry is never lost.
  function automatic logic [CODE_W_MAX-1:0] centre_code(
    input logic [CODE_W_MAX-1:0] first,
    input logic [CODE_W_MAX-1:0] last
  );
    logic [CODE_W_MAX:0] sum;
    sum = {1'b0, first} + {1'b0, last};
    return sum[CODE_W_MAX:1];
  endfunction

endpackage

// File: rtl/hyperbus_delay_cal_if.sv
// Test-read handshake between the calibration controller and the transaction engine.
interface hyperbus_delay_cal_if;

  logic test_req;
  logic test_ack;
  logic test_pass;

  modport master (
    output test_req,
    input  test_ack,
    input  test_pass
  );

  modport slave (
    input  test_req,
    output test_ack,
    output test_pass
  );

endinterface

// File: rtl/hyperbus_cal_window_tracker.sv
// Tracks the current passing run and the longest run seen so far during a sweep.
module hyperbus_cal_window_tracker
  import hyperbus_delay_cal_pkg::*;
#(
  parameter int BIT_WIDTH = CAL_BIT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 upd_i,
  input  logic                 pass_i,
  input  logic [BIT_WIDTH-1:0] code_i,
  output logic [BIT_WIDTH-1:0] best_start_o,
  output logic [BIT_WIDTH:0]   best_len_o
);

  logic [BIT_WIDTH-1:0] cur_start_reg, cur_start_next;
  logic [BIT_WIDTH:0]   cur_len_reg, cur_len_next;
  logic [BIT_WIDTH-1:0] best_start_reg, best_start_next;
  logic [BIT_WIDTH:0]   best_len_reg, best_len_next;
  logic [BIT_WIDTH-1:0] run_start;
  logic [BIT_WIDTH:0]   cur_len_inc;

  assign run_start   = (cur_len_reg == '0) ? code_i : cur_start_reg;
  assign cur_len_inc = cur_len_reg + (BIT_WIDTH+1)'(1);

  always_comb begin
    cur_start_next  = cur_start_reg;
    cur_len_next    = cur_len_reg;
    best_start_next = best_start_reg;
    best_len_next   = best_len_reg;
    if (clear_i) begin
      cur_start_next  = '0;
      cur_len_next    = '0;
      best_start_next = '0;
      best_len_next   = '0;
    end else if (upd_i) begin
      if (pass_i) begin
        cur_start_next = run_start;
        cur_len_next   = cur_len_inc;
        // Strictly longer only, so the earliest of equal-length windows wins.
        if (cur_len_inc > best_len_reg) begin
          best_start_next = run_start;
          best_len_next   = cur_len_inc;
        end
      end else begin
        cur_len_next = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cur_start_reg  <= '0;
      cur_len_reg    <= '0;
      best_start_reg <= '0;
      best_len_reg   <= '0;
    end else begin
      cur_start_reg  <= cur_start_next;
      cur_len_reg    <= cur_len_next;
      best_start_reg <= best_start_next;
      best_len_reg   <= best_len_next;
    end
  end

  assign best_start_o = best_start_reg;
  assign best_len_o   = best_len_reg;

endmodule

// File: rtl/hyperbus_delay_cal.sv
// Delay-line calibration: sweeps every tap, test-reads each, and programs the
// centre of the longest passing window (or a default code if none pass).
module hyperbus_delay_cal
  import hyperbus_delay_cal_pkg::*;
#(
  parameter int BIT_WIDTH    = CAL_BIT_WIDTH,
  parameter int DEFAULT_CODE = 4,
  parameter int SETTLE_CYC   = 4,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 cfg_manual_i,
  input  logic [BIT_WIDTH-1:0] cfg_manual_code_i,
  hyperbus_delay_cal_if.master test_if,
  output logic [BIT_WIDTH-1:0] delay_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fail_o,
  output logic [BIT_WIDTH-1:0] win_first_o,
  output logic [BIT_WIDTH-1:0] win_last_o
);

  localparam logic [2:0] S_IDLE   = CAL_IDLE;
  localparam logic [2:0] S_SET    = CAL_SET;
  localparam logic [2:0] S_SETTLE = CAL_SETTLE;
  localparam logic [2:0] S_TEST   = CAL_TEST;
  localparam logic [2:0] S_EVAL   = CAL_EVAL;
  localparam logic [2:0] S_FINISH = CAL_FINISH;

  localparam int TIMER_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam logic [BIT_WIDTH-1:0] LAST_CODE = '1;

  logic [2:0]           state_reg;
  logic [BIT_WIDTH-1:0] code_reg;
  logic [BIT_WIDTH-1:0] delay_reg;
  logic [BIT_WIDTH-1:0] win_first_reg;
  logic [BIT_WIDTH-1:0] win_last_reg;
  logic [TIMER_W-1:0]   timer_reg;
  logic                 result_reg;
  logic                 fail_reg;
  logic                 done_reg;

  logic                 start_accept;
  logic [BIT_WIDTH-1:0] best_start;
  logic [BIT_WIDTH:0]   best_len;
  logic [BIT_WIDTH-1:0] win_last_calc;
  logic [BIT_WIDTH-1:0] centre_calc;

  assign start_accept  = (state_reg == S_IDLE) && !cfg_manual_i && start_i;
  assign win_last_calc = BIT_WIDTH'({1'b0, best_start} + best_len - (BIT_WIDTH+1)'(1));
  assign centre_calc   = BIT_WIDTH'(centre_code(CODE_W_MAX'(best_start), CODE_W_MAX'(win_last_calc)));

  hyperbus_cal_window_tracker #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_tracker (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (start_accept),
    .upd_i        (state_reg == S_EVAL),
    .pass_i       (result_reg),
    .code_i       (code_reg),
    .best_start_o (best_start),
    .best_len_o   (best_len)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg     <= S_IDLE;
      code_reg      <= '0;
      delay_reg     <= BIT_WIDTH'(DEFAULT_CODE);
      win_first_reg <= '0;
      win_last_reg  <= '0;
      timer_reg     <= '0;
      result_reg    <= 1'b0;
      fail_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (cfg_manual_i) begin
            delay_reg <= cfg_manual_code_i;
          end else if (start_i) begin
            code_reg  <= '0;
            fail_reg  <= 1'b0;
            timer_reg <= '0;
            state_reg <= S_SET;
          end
        end
        S_SET: begin
          delay_reg <= code_reg;
          timer_reg <= '0;
          state_reg <= S_SETTLE;
        end
        S_SETTLE: begin
          if (timer_reg == TIMER_W'(SETTLE_CYC - 1)) begin
            timer_reg <= '0;
            state_reg <= S_TEST;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end
        S_TEST: begin
          // A missing ack is scored as a failing tap rather than stalling the sweep.
          if (test_if.test_ack) begin
            result_reg <= test_if.test_pass;
            timer_reg  <= '0;
            state_reg  <= S_EVAL;
          end else if (timer_reg == TIMER_W'(TIMEOUT_CYC - 1)) begin
            result_reg <= 1'b0;
            timer_reg  <= '0;
            state_reg  <= S_EVAL;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end
        S_EVAL: begin
          if (code_reg == LAST_CODE) begin
            state_reg <= S_FINISH;
          end else begin
            code_reg  <= code_reg + BIT_WIDTH'(1);
            state_reg <= S_SET;
          end
        end
        S_FINISH: begin
          if (best_len != '0) begin
            win_first_reg <= best_start;
            win_last_reg  <= win_last_calc;
            delay_reg     <= centre_calc;
          end else begin
            fail_reg  <= 1'b1;
            delay_reg <= BIT_WIDTH'(DEFAULT_CODE);
          end
          done_reg  <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign test_if.test_req = (state_reg == S_TEST);
  assign delay_o          = delay_reg;
  assign busy_o           = (state_reg != S_IDLE);
  assign done_o           = done_reg;
  assign fail_o           = fail_reg;
  assign win_first_o      = win_first_reg;
  assign win_last_o       = win_last_reg;

endmodule
